tlk2711_rx_frame_parser: RTL and testbench

- Sits directly downstream of the TLK2711 RX clock-domain-crossing FIFO, in the system `clk` domain.
- Consumes the 16-bit data word and 2 K-flags per cycle and hunts for frame delimiters.
- Strips the length and checksum words, forwards payload as a valid/sof/last stream to the DMA write path, and reports per-frame status and saturating statistics to the register block.

---
 rtl/tlk2711_rx_frame_parser.sv | 264 ++++++++++++++++++++++++++
 tb/tb_tlk2711_rx_frame_parser.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_rx_frame_parser.sv
// TLK2711 RX frame parser: hunts SOF/EOF delimiters, strips LEN and CSUM words,
// streams payload with sof/last and keeps per-frame status plus saturating statistics.
module tlk2711_rx_frame_parser #(
  parameter int DATAWIDTH = 16,
  parameter int MAX_LEN   = 4096,
  parameter int LEN_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_soft_rst,
  input  logic                 i_rx_valid,
  input  logic [DATAWIDTH-1:0] i_rx_data,
  input  logic [1:0]           i_rx_k,
  output logic [DATAWIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_sof,
  output logic                 o_last,
  output logic                 o_frame_done,
  output logic                 o_frame_ok,
  output logic [3:0]           o_err_flags,
  input  logic [3:0]           i_err_clr,
  output logic [31:0]          o_frame_cnt,
  output logic [15:0]          o_err_cnt
);

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_EOF_CHK = 3'd4;

  localparam logic [DATAWIDTH-1:0] W_SOF  = 16'h50FB;
  localparam logic [DATAWIDTH-1:0] W_EOF  = 16'h50FD;
  localparam logic [DATAWIDTH-1:0] W_IDLE = 16'hC5BC;
  localparam logic [DATAWIDTH-1:0] W_ZERO = 16'h0000;
  localparam logic [DATAWIDTH-1:0] W_MAX  = 16'(MAX_LEN);

  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [31:0]      FCNT_MAX = 32'hFFFF_FFFF;
  localparam logic [15:0]      ECNT_MAX = 16'hFFFF;

  localparam int E_LEN  = 0;
  localparam int E_CTRL = 1;
  localparam int E_CSUM = 2;
  localparam int E_EOF  = 3;

  logic [2:0]           state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] sum_q, sum_d;
  logic                 bad_q, bad_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sof_q, sof_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic [3:0]           flags_q, flags_d;
  logic [31:0]          fcnt_q, fcnt_d;
  logic [15:0]          ecnt_q, ecnt_d;
  logic [3:0]           err_set;

  logic w_k01, w_sof, w_eof, w_idle, w_data, len_ok, is_last;

  assign w_k01   = i_rx_valid && (i_rx_k == 2'b01);
  assign w_sof   = w_k01 && (i_rx_data == W_SOF);
  assign w_eof   = w_k01 && (i_rx_data == W_EOF);
  assign w_idle  = w_k01 && (i_rx_data == W_IDLE);
  assign w_data  = i_rx_valid && (i_rx_k == 2'b00);
  assign len_ok  = (i_rx_data != W_ZERO) && (i_rx_data <= W_MAX);
  assign is_last = (cnt_q == (len_q - LEN_ONE));

  // Frame FSM, payload datapath, status and statistics next-state
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    bad_d   = bad_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    err_set = 4'b0000;

    if (i_rx_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (w_sof) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LEN: begin
          if (w_data) begin
            if (len_ok) begin
              len_d   = i_rx_data[LEN_W-1:0];
              cnt_d   = LEN_ZERO;
              sum_d   = W_ZERO;
              bad_d   = 1'b0;
              state_d = ST_PAYLOAD;
            end else begin
              err_set[E_LEN] = 1'b1;
              done_d         = 1'b1;
              state_d        = ST_HUNT;
            end
          end else if (w_sof) begin
            state_d = ST_LEN;
          end else begin
            err_set[E_CTRL] = 1'b1;
            done_d          = 1'b1;
            state_d         = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          if (w_data) begin
            data_d  = i_rx_data;
            valid_d = 1'b1;
            sof_d   = (cnt_q == LEN_ZERO);
            last_d  = is_last;
            sum_d   = sum_q + i_rx_data;
            cnt_d   = cnt_q + LEN_ONE;
            if (is_last) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            // Any K word aborts; a SOF resyncs straight into the next frame
            err_set[E_CTRL] = 1'b1;
            done_d          = 1'b1;
            if (w_sof) begin
              state_d = ST_LEN;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_CSUM: begin
          if (w_data) begin
            if (i_rx_data != sum_q) begin
              err_set[E_CSUM] = 1'b1;
              bad_d           = 1'b1;
            end else begin
              bad_d = bad_q;
            end
            state_d = ST_EOF_CHK;
          end else begin
            err_set[E_CTRL] = 1'b1;
            done_d          = 1'b1;
            if (w_sof) begin
              state_d = ST_LEN;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_EOF_CHK: begin
          done_d = 1'b1;
          if (w_eof) begin
            ok_d    = !bad_q;
            state_d = ST_HUNT;
          end else begin
            err_set[E_EOF] = 1'b1;
            if (w_sof) begin
              state_d = ST_LEN;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Set wins over a same-cycle clear
    flags_d = (flags_q & ~i_err_clr) | err_set;

    if (done_d && ok_d && (fcnt_q != FCNT_MAX)) begin
      fcnt_d = fcnt_q + 32'd1;
    end else begin
      fcnt_d = fcnt_q;
    end

    if (done_d && !ok_d && (ecnt_q != ECNT_MAX)) begin
      ecnt_d = ecnt_q + 16'd1;
    end else begin
      ecnt_d = ecnt_q;
    end

    if (i_soft_rst) begin
      state_d = ST_HUNT;
      len_d   = LEN_ZERO;
      cnt_d   = LEN_ZERO;
      sum_d   = W_ZERO;
      bad_d   = 1'b0;
      data_d  = W_ZERO;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      ok_d    = 1'b0;
      flags_d = 4'b0000;
      fcnt_d  = 32'd0;
      ecnt_d  = 16'd0;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      len_q   <= LEN_ZERO;
      cnt_q   <= LEN_ZERO;
      sum_q   <= W_ZERO;
      bad_q   <= 1'b0;
      data_q  <= W_ZERO;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      flags_q <= 4'b0000;
      fcnt_q  <= 32'd0;
      ecnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      bad_q   <= bad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      flags_q <= flags_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_sof        = sof_q;
  assign o_last       = last_q;
  assign o_frame_done = done_q;
  assign o_frame_ok   = ok_q;
  assign o_err_flags  = flags_q;
  assign o_frame_cnt  = fcnt_q;
  assign o_err_cnt    = ecnt_q;

endmodule

// File: tb/tb_tlk2711_rx_frame_parser.sv
// Randomized bench for tlk2711_rx_frame_parser; expectations come from a frame-level
// model that knows each frame's payload, outcome and error class before it is sent.
module tb_tlk2711_rx_frame_parser;

  localparam logic [15:0] W_SOF  = 16'h50FB;
  localparam logic [15:0] W_EOF  = 16'h50FD;
  localparam logic [15:0] W_IDLE = 16'hC5BC;
  localparam logic [1:0]  KC     = 2'b01;
  localparam logic [1:0]  KD     = 2'b00;

  localparam int F_GOOD       = 0;
  localparam int F_CSUM       = 1;
  localparam int F_NOEOF      = 2;
  localparam int F_LENERR     = 3;
  localparam int F_ABORT_SOF  = 4;
  localparam int F_ABORT_IDLE = 5;
  localparam int F_SOF_AT_EOF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_soft_rst;
  logic        i_rx_valid;
  logic [15:0] i_rx_data;
  logic [1:0]  i_rx_k;
  logic [3:0]  i_err_clr;
  logic [15:0] o_data;
  logic        o_valid, o_sof, o_last, o_frame_done, o_frame_ok;
  logic [3:0]  o_err_flags;
  logic [31:0] o_frame_cnt;
  logic [15:0] o_err_cnt;

  always #5 clk = ~clk;

  tlk2711_rx_frame_parser dut (
    .clk         (clk),
    .rst         (rst),
    .i_soft_rst  (i_soft_rst),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .i_rx_k      (i_rx_k),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_last      (o_last),
    .o_frame_done(o_frame_done),
    .o_frame_ok  (o_frame_ok),
    .o_err_flags (o_err_flags),
    .i_err_clr   (i_err_clr),
    .o_frame_cnt (o_frame_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          gap_pct  = 0;
  logic [3:0]  clr_next = 4'b0000;
  logic [17:0] exp_beats[$];
  logic        exp_done[$];
  logic [3:0]  exp_flags = 4'b0000;
  logic [31:0] exp_fcnt  = 32'd0;
  logic [15:0] exp_ecnt  = 16'd0;
  logic [15:0] pl[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: every beat and done pulse must match the next model entry
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (o_valid === 1'b1) begin
        if (exp_beats.size() == 0) check_eq("beat_spurious", 64'(o_valid), 64'd0);
        else check_eq("beat", {o_data, o_sof, o_last}, exp_beats.pop_front());
      end else if (o_sof === 1'b1 || o_last === 1'b1) begin
        check_eq("sof_last_without_valid", {o_sof, o_last}, 64'd0);
      end
      if (o_frame_done === 1'b1) begin
        if (exp_done.size() == 0) check_eq("done_spurious", 64'(o_frame_done), 64'd0);
        else check_eq("done_ok", 64'(o_frame_ok), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic put_word(input logic [1:0] k, input logic [15:0] d);
    while (gap_pct != 0 && $urandom_range(99, 0) < gap_pct) begin
      @(negedge clk);
      i_rx_valid = 1'b0;
      i_rx_k     = 2'($urandom);
      i_rx_data  = 16'($urandom);
      i_err_clr  = 4'b0000;
    end
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_k     = k;
    i_rx_data  = d;
    i_err_clr  = clr_next;
    clr_next   = 4'b0000;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      i_rx_valid = 1'b0;
      i_err_clr  = 4'b0000;
    end
  endtask

  task automatic note_done(input bit ok, input int flag);
    exp_done.push_back(ok);
    if (flag >= 0) exp_flags[flag] = 1'b1;
    if (ok) begin
      if (exp_fcnt != 32'hFFFF_FFFF) exp_fcnt++;
    end else begin
      if (exp_ecnt != 16'hFFFF) exp_ecnt++;
    end
  endtask

  // One frame on the wire; payload comes from pl, outcome from the frame kind
  task automatic frame(input int kind, input logic [15:0] len_w, input int cut,
                       input logic [15:0] delta, input bit with_sof);
    logic [15:0] s;
    int          n, nb, flag;
    bit          ok;
    s = 16'h0000;
    foreach (pl[i]) s = s + pl[i];
    n = pl.size();
    case (kind)
      F_LENERR:                 begin nb = 0;   ok = 1'b0; flag = 0; end
      F_ABORT_SOF, F_ABORT_IDLE: begin nb = cut; ok = 1'b0; flag = 1; end
      F_CSUM:                   begin nb = n;   ok = 1'b0; flag = 2; end
      F_NOEOF, F_SOF_AT_EOF:    begin nb = n;   ok = 1'b0; flag = 3; end
      default:                  begin nb = n;   ok = 1'b1; flag = -1; end
    endcase
    for (int i = 0; i < nb; i++) exp_beats.push_back({pl[i], i == 0, i == n - 1});
    note_done(ok, flag);

    if (with_sof) put_word(KC, W_SOF);
    put_word(KD, len_w);
    if (kind == F_LENERR) return;
    if (kind == F_ABORT_SOF || kind == F_ABORT_IDLE) begin
      for (int i = 0; i < cut; i++) put_word(KD, pl[i]);
      put_word(KC, (kind == F_ABORT_SOF) ? W_SOF : W_IDLE);
      return;
    end
    for (int i = 0; i < n; i++) put_word(KD, pl[i]);
    put_word(KD, s + ((kind == F_CSUM) ? delta : 16'h0000));
    case (kind)
      F_NOEOF:      put_word(KC, W_IDLE);
      F_SOF_AT_EOF: put_word(KC, W_SOF);
      default:      put_word(KC, W_EOF);
    endcase
  endtask

  task automatic set_pl3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input int n);
    pl = {};
    pl.push_back(a);
    if (n > 1) pl.push_back(b);
    if (n > 2) pl.push_back(c);
  endtask

  task automatic status(input string tag);
    idle_cycles(3);
    check_eq({tag, "_flags"}, 64'(o_err_flags), 64'(exp_flags));
    check_eq({tag, "_frame_cnt"}, 64'(o_frame_cnt), 64'(exp_fcnt));
    check_eq({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(exp_ecnt));
    check_eq({tag, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
    check_eq({tag, "_dones_left"}, 64'(exp_done.size()), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_stream"}, {o_data, o_valid, o_sof, o_last, o_frame_done, o_frame_ok}, 64'd0);
    check_eq({tag, "_stats"}, {o_err_flags, o_frame_cnt, o_err_cnt}, 64'd0);
    exp_flags = 4'b0000;
    exp_fcnt  = 32'd0;
    exp_ecnt  = 16'd0;
  endtask

  initial begin
    int kind, n, cut, r;
    bit pending;
    logic [15:0] len_w, delta;
    rst = 1'b1; i_soft_rst = 1'b0; i_rx_valid = 1'b0; i_rx_data = 16'h0000;
    i_rx_k = 2'b00; i_err_clr = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    set_pl3(16'h0001, 16'h0002, 16'h0003, 3);
    frame(F_GOOD, 16'd3, 0, 16'h0, 1'b1);
    status("basic");

    gap_pct = 50;
    frame(F_GOOD, 16'd3, 0, 16'h0, 1'b1);
    status("gapped");
    gap_pct = 0;

    set_pl3(16'hFFFF, 16'h0002, 16'h0, 2);
    frame(F_GOOD, 16'd2, 0, 16'h0, 1'b1);
    frame(F_CSUM, 16'd2, 0, 16'h0001, 1'b1);
    status("wrap_csum");

    frame(F_LENERR, 16'd0, 0, 16'h0, 1'b1);
    frame(F_LENERR, 16'd4097, 0, 16'h0, 1'b1);
    set_pl3(16'h1234, 16'h0, 16'h0, 1);
    frame(F_GOOD, 16'd1, 0, 16'h0, 1'b1);
    status("len_err");

    pl = {};
    for (int i = 0; i < 5; i++) pl.push_back(16'(16'h0100 + i));
    frame(F_ABORT_SOF, 16'd5, 2, 16'h0, 1'b1);
    set_pl3(16'hA5A5, 16'h5A5A, 16'h0, 2);
    frame(F_GOOD, 16'd2, 0, 16'h0, 1'b0);
    frame(F_NOEOF, 16'd2, 0, 16'h0, 1'b1);
    status("abort_noeof");

    pl = {};
    for (int i = 0; i < 4096; i++) pl.push_back(16'($urandom));
    frame(F_GOOD, 16'd4096, 0, 16'h0, 1'b1);
    status("max_len");

    // Clear all flags, then clear len_err in the same cycle it is set again
    @(negedge clk); i_rx_valid = 1'b0; i_err_clr = 4'hF;
    @(negedge clk); i_err_clr = 4'h0; exp_flags = 4'b0000;
    check_eq("flags_w1c", 64'(o_err_flags), 64'd0);
    put_word(KC, W_SOF);
    note_done(1'b0, 0);
    clr_next = 4'b0001;
    put_word(KD, 16'h0000);
    status("set_wins");

    put_word(KC, W_SOF); put_word(KD, 16'd4);
    put_word(KD, 16'h1111); put_word(KD, 16'h2222);
    exp_beats.push_back({16'h1111, 1'b1, 1'b0});
    exp_beats.push_back({16'h2222, 1'b0, 1'b0});
    idle_cycles(2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); check_cleared("mid_rst");
    rst = 1'b0;
    set_pl3(16'h0010, 16'h0020, 16'h0030, 3);
    frame(F_GOOD, 16'd3, 0, 16'h0, 1'b1);
    status("after_rst");

    put_word(KC, W_SOF); put_word(KD, 16'd3); put_word(KD, 16'h7777);
    exp_beats.push_back({16'h7777, 1'b1, 1'b0});
    idle_cycles(2);
    @(negedge clk); i_soft_rst = 1'b1;
    @(negedge clk); i_soft_rst = 1'b0; check_cleared("soft_rst");
    frame(F_GOOD, 16'd3, 0, 16'h0, 1'b1);
    status("after_soft_rst");

    gap_pct = 30;
    pending = 1'b0;
    for (int f = 0; f < 150; f++) begin
      r = $urandom_range(99, 0);
      kind = (r < 45) ? F_GOOD : (r < 55) ? F_CSUM : (r < 63) ? F_NOEOF :
             (r < 73) ? F_LENERR : (r < 83) ? F_ABORT_SOF : (r < 91) ? F_ABORT_IDLE : F_SOF_AT_EOF;
      if (!pending) begin
        repeat ($urandom_range(3, 0)) begin
          r = $urandom_range(2, 0);
          if (r == 0) put_word(KC, W_IDLE);
          else if (r == 1) put_word(KD, 16'($urandom));
          else put_word(2'b11, 16'($urandom));
        end
      end
      n = ($urandom_range(9, 0) == 0) ? $urandom_range(40, 9) : $urandom_range(8, 1);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(16'($urandom));
      cut = $urandom_range(n - 1, 0);
      delta = 16'($urandom_range(65535, 1));
      if (kind == F_LENERR) len_w = ($urandom_range(1, 0) == 0) ? 16'd0 : 16'($urandom_range(65535, 4097));
      else len_w = 16'(n);
      frame(kind, len_w, cut, delta, pending ? 1'($urandom_range(1, 0)) : 1'b1);
      pending = (kind == F_ABORT_SOF) || (kind == F_SOF_AT_EOF);
    end
    if (pending) begin
      set_pl3(16'hBEEF, 16'h0, 16'h0, 1);
      frame(F_GOOD, 16'd1, 0, 16'h0, 1'b0);
    end
    status("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
